ifid_queue: RTL

IFID_QUEUE -- requirements
Module: ifid_queue

---
 rtl/ifid_pkg.sv | 28 ++
 rtl/ifid_fields.sv | 28 ++
 rtl/ifid_queue.sv | 111 +++++++++++
 3 files changed

// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID instruction queue.
// Holds the RV32 instruction field bit positions and the queue entry type.
// The entry PC is sized for the widest supported XLEN (64); narrower
// configurations store the PC zero-extended and the unused upper bits are
// constant and trimmed by synthesis.
package ifid_pkg;

  localparam int unsigned MaxXlen = 64;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeW   = 7;
  localparam int unsigned RdLsb     = 7;
  localparam int unsigned Funct3Lsb = 12;
  localparam int unsigned Funct3W   = 3;
  localparam int unsigned Rs1Lsb    = 15;
  localparam int unsigned Rs2Lsb    = 20;
  localparam int unsigned RegW      = 5;
  localparam int unsigned Funct7Lsb = 25;
  localparam int unsigned Funct7W   = 7;
  localparam int unsigned CsrLsb    = 20;
  localparam int unsigned CsrW      = 12;

  typedef struct packed {
    logic [MaxXlen-1:0] pc;
    logic [31:0]        instr;
  } entry_t;

endpackage

// File: rtl/ifid_fields.sv
// Combinational RV32 instruction field extraction, shared by pipeline stages.
// Ports:
//   instr    - 32-bit instruction word
//   opcode   - [6:0]      rd     - [11:7]   funct3 - [14:12]
//   rs1      - [19:15]    rs2    - [24:20]  funct7 - [31:25]
//   csr_addr - [31:20]
module ifid_fields
  import ifid_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [11:0] csr_addr
);

  assign opcode   = instr[OpcodeLsb +: OpcodeW];
  assign rd       = instr[RdLsb +: RegW];
  assign funct3   = instr[Funct3Lsb +: Funct3W];
  assign rs1      = instr[Rs1Lsb +: RegW];
  assign rs2      = instr[Rs2Lsb +: RegW];
  assign funct7   = instr[Funct7Lsb +: Funct7W];
  assign csr_addr = instr[CsrLsb +: CsrW];

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: a DEPTH-entry FIFO of {pc, instr} between fetch
// and decode, with synchronous flush and combinational field decode of the
// head entry. An empty queue presents an all-zero bubble to decode.
// Ports:
//   clk, reset (async active-low), flush (sync discard)
//   in_valid/in_ready/in_pc/in_instr      - push side from IF
//   out_valid/out_ready/out_pc/out_instr  - pop side to ID
//   rs1, rs2, rd, opcode, funct3, funct7, csr_addr - head decode
//   count                                  - occupied entries
module ifid_queue
  import ifid_pkg::*;
#(
  parameter int unsigned XLEN  = 32,  // must not exceed MaxXlen
  parameter int unsigned DEPTH = 4    // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [6:0]                 opcode,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7,
  output logic [11:0]                csr_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic            push, pop;

  // Full blocks a push even if a pop happens in the same cycle.
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q].pc    <= MaxXlen'(in_pc);
      mem_q[wr_ptr_q].instr <= in_instr;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = out_valid ? head.pc[XLEN-1:0] : '0;
  assign out_instr = out_valid ? head.instr : '0;

  if (XLEN < MaxXlen) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^head.pc[MaxXlen-1:XLEN];
  end

  ifid_fields u_fields (
    .instr    (out_instr),
    .opcode   (opcode),
    .rd       (rd),
    .funct3   (funct3),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct7   (funct7),
    .csr_addr (csr_addr)
  );

endmodule
